// File: rtl/zone_alarm_ctrl.sv
// zone_alarm_ctrl: multi-zone intrusion alarm sequencer.
// Exit and entry delays, a timed siren with auto-rearm, a zone bypass
// latched at arm time, and a sticky log of the zones that tripped.
// Optional build macro ZONE_ALARM_TAMPER_EN adds a tamper input that forces
// ALARM from any state, plus a sticky tamper_log output.
module zone_alarm_ctrl #(
  parameter int               ZONES        = 4,
  parameter logic [ZONES-1:0] INSTANT_MASK = '0,
  parameter int               EXIT_DLY     = 8,
  parameter int               ENTRY_DLY    = 8,
  parameter int               SIREN_TIME   = 16,
  parameter int               CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             disarm,
  input  logic [ZONES-1:0] zone,
  input  logic [ZONES-1:0] bypass,
`ifdef ZONE_ALARM_TAMPER_EN
  input  logic             tamper,
  output logic             tamper_log,
`endif
  output logic [2:0]       state,
  output logic             armed,
  output logic             pending,
  output logic             siren,
  output logic             arm_fault,
  output logic [ZONES-1:0] trip_log
);

  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DLY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ZONES-1:0] bypass_reg, bypass_next;
  logic [ZONES-1:0] trip_reg, trip_next;
  logic             fault_reg, fault_next;
  logic             armed_reg, pending_reg, siren_reg;

  // Zones that count: open and not bypassed, split into instant and delayed.
  logic [ZONES-1:0] act, inst, dly;
  assign act  = zone & ~bypass_reg;
  assign inst = act & INSTANT_MASK;
  assign dly  = act & ~INSTANT_MASK;

`ifdef ZONE_ALARM_TAMPER_EN
  logic tamper_reg, tamper_next;
`endif

  // State, counter, latches and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= DISARMED;
      cnt_reg     <= '0;
      bypass_reg  <= '0;
      trip_reg    <= '0;
      fault_reg   <= 1'b0;
      armed_reg   <= 1'b0;
      pending_reg <= 1'b0;
      siren_reg   <= 1'b0;
`ifdef ZONE_ALARM_TAMPER_EN
      tamper_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bypass_reg  <= bypass_next;
      trip_reg    <= trip_next;
      fault_reg   <= fault_next;
      armed_reg   <= (state_next == ARMED) || (state_next == ENTRY_DELAY) ||
                     (state_next == ALARM);
      pending_reg <= (state_next == EXIT_DELAY) || (state_next == ENTRY_DELAY);
      siren_reg   <= (state_next == ALARM);
`ifdef ZONE_ALARM_TAMPER_EN
      tamper_reg  <= tamper_next;
`endif
    end
  end

  // Next-state logic; priority is disarm, tamper, instant, delayed, expiry.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bypass_next = bypass_reg;
    trip_next   = trip_reg;
    fault_next  = 1'b0;
`ifdef ZONE_ALARM_TAMPER_EN
    tamper_next = tamper_reg;
`endif
    if (disarm) begin
      // In DISARMED a disarm (alone or with arm) is simply a no-op.
      if (state_reg != DISARMED) begin
        state_next = DISARMED;
        cnt_next   = '0;
      end
`ifdef ZONE_ALARM_TAMPER_EN
    end else if (tamper) begin
      state_next  = ALARM;
      cnt_next    = SIREN_LOAD;
      tamper_next = 1'b1;
`endif
    end else begin
      unique case (state_reg)
        DISARMED: begin
          if (arm) begin
            if ((zone & ~bypass) == '0) begin
              state_next  = EXIT_DELAY;
              cnt_next    = EXIT_LOAD;
              bypass_next = bypass;
              trip_next   = '0;
`ifdef ZONE_ALARM_TAMPER_EN
              tamper_next = 1'b0;
`endif
            end else begin
              fault_next = 1'b1;
            end
          end
        end
        EXIT_DELAY: begin
          if (cnt_reg == '0) state_next = ARMED;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        ARMED: begin
          if (inst != '0) begin
            state_next = ALARM;
            cnt_next   = SIREN_LOAD;
            trip_next  = trip_reg | act;
          end else if (dly != '0) begin
            state_next = ENTRY_DELAY;
            cnt_next   = ENTRY_LOAD;
            trip_next  = trip_reg | act;
          end
        end
        ENTRY_DELAY: begin
          trip_next = trip_reg | act;
          if ((inst != '0) || (cnt_reg == '0)) begin
            state_next = ALARM;
            cnt_next   = SIREN_LOAD;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ALARM: begin
          trip_next = trip_reg | act;
          if (cnt_reg == '0) state_next = ARMED;
          else               cnt_next   = cnt_reg - 1'b1;
        end
        default: begin
          state_next = DISARMED;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign state     = state_reg;
  assign armed     = armed_reg;
  assign pending   = pending_reg;
  assign siren     = siren_reg;
  assign arm_fault = fault_reg;
  assign trip_log  = trip_reg;
`ifdef ZONE_ALARM_TAMPER_EN
  assign tamper_log = tamper_reg;
`endif

endmodule

// File: tb/tb_zone_alarm_ctrl.sv
// Directed bench for zone_alarm_ctrl with ZONES=4, INSTANT_MASK=4'b1100,
// EXIT_DLY=4, ENTRY_DLY=3, SIREN_TIME=5.
module tb_zone_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic [3:0] zone = '0;
  logic [3:0] bypass = '0;
  logic [2:0] state;
  logic       armed, pending, siren, arm_fault;
  logic [3:0] trip_log;
`ifdef ZONE_ALARM_TAMPER_EN
  logic       tamper = 1'b0;
  logic       tamper_log;
`endif

  int vectors = 0;
  int miscompares = 0;

  zone_alarm_ctrl #(
    .ZONES(4), .INSTANT_MASK(4'b1100), .EXIT_DLY(4), .ENTRY_DLY(3),
    .SIREN_TIME(5), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm),
    .zone(zone), .bypass(bypass),
`ifdef ZONE_ALARM_TAMPER_EN
    .tamper(tamper), .tamper_log(tamper_log),
`endif
    .state(state), .armed(armed), .pending(pending), .siren(siren),
    .arm_fault(arm_fault), .trip_log(trip_log)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the full status bundle in one call.
  task automatic chk_all(input string tag, input logic [2:0] s, input logic a,
                         input logic p, input logic sr, input logic f,
                         input logic [3:0] tl);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".armed"}, 32'(armed), 32'(a));
    chk({tag, ".pending"}, 32'(pending), 32'(p));
    chk({tag, ".siren"}, 32'(siren), 32'(sr));
    chk({tag, ".arm_fault"}, 32'(arm_fault), 32'(f));
    chk({tag, ".trip_log"}, 32'(trip_log), 32'(tl));
    $display("vec %s: state=%0d armed=%0b pending=%0b siren=%0b fault=%0b trip=%b",
             tag, state, armed, pending, siren, arm_fault, trip_log);
  endtask

  // Accepted arm followed by the full exit delay, ending in ARMED.
  task automatic arm_and_wait(input logic [3:0] byp);
    bypass = byp; arm = 1'b1;
    step();
    arm = 1'b0; bypass = '0;
    repeat (4) step();
  endtask

  initial begin
    // Reset state.
    #2;
    chk_all("reset", 3'd0, 0, 0, 0, 0, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
    chk_all("post_reset", 3'd0, 0, 0, 0, 0, 4'b0000);

    // 1: clean arm, exactly 4 cycles of EXIT_DELAY.
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk_all("t1_exit0", 3'd1, 0, 1, 0, 0, 4'b0000);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_all("t1_exit", 3'd1, 0, 1, 0, 0, 4'b0000);
    end
    step();
    chk_all("t1_armed", 3'd2, 1, 0, 0, 0, 4'b0000);

    // 2: arm rejected with an open zone, then accepted with it bypassed.
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk_all("t2_disarmed", 3'd0, 0, 0, 0, 0, 4'b0000);
    zone = 4'b0010; arm = 1'b1;
    step();
    arm = 1'b0;
    chk_all("t2_fault", 3'd0, 0, 0, 0, 1, 4'b0000);
    step();
    chk_all("t2_fault_end", 3'd0, 0, 0, 0, 0, 4'b0000);
    arm_and_wait(4'b0010);
    chk_all("t2_bypass_armed", 3'd2, 1, 0, 0, 0, 4'b0000);
    zone = 4'b0000;
    step();
    zone = 4'b0010;
    step();
    chk_all("t2_bypass_toggle", 3'd2, 1, 0, 0, 0, 4'b0000);
    zone = 4'b0000;

    // 3: delayed zone -> 3 cycles entry, 5 cycles siren, back to ARMED.
    zone = 4'b0001;
    step();
    zone = 4'b0000;
    chk_all("t3_entry0", 3'd3, 1, 1, 0, 0, 4'b0001);
    repeat (2) begin
      step();
      chk_all("t3_entry", 3'd3, 1, 1, 0, 0, 4'b0001);
    end
    step();
    chk_all("t3_siren0", 3'd4, 1, 0, 1, 0, 4'b0001);
    repeat (4) begin
      step();
      chk_all("t3_siren", 3'd4, 1, 0, 1, 0, 4'b0001);
    end
    step();
    chk_all("t3_rearm", 3'd2, 1, 0, 0, 0, 4'b0001);

    // 4: instant zone, disarm on 2nd siren cycle, trip_log retained.
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    arm_and_wait(4'b0000);
    chk_all("t4_armed", 3'd2, 1, 0, 0, 0, 4'b0000);
    zone = 4'b1000;
    step();
    chk_all("t4_alarm", 3'd4, 1, 0, 1, 0, 4'b1000);
    step();
    chk_all("t4_siren2", 3'd4, 1, 0, 1, 0, 4'b1000);
    disarm = 1'b1;
    step();
    disarm = 1'b0; zone = 4'b0000;
    chk_all("t4_disarm", 3'd0, 0, 0, 0, 0, 4'b1000);
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk_all("t4_rearm_clear", 3'd1, 0, 1, 0, 0, 4'b0000);
    repeat (4) step();
    chk_all("t4_armed2", 3'd2, 1, 0, 0, 0, 4'b0000);

    // 5a: disarm on 2nd entry cycle, siren never raised.
    zone = 4'b0001;
    step();
    zone = 4'b0000;
    chk_all("t5_entry0", 3'd3, 1, 1, 0, 0, 4'b0001);
    step();
    chk_all("t5_entry1", 3'd3, 1, 1, 0, 0, 4'b0001);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    chk_all("t5_disarm", 3'd0, 0, 0, 0, 0, 4'b0001);

    // 5b: instant zone during ENTRY_DELAY -> immediate ALARM.
    arm_and_wait(4'b0000);
    zone = 4'b0001;
    step();
    chk_all("t5_entry_b", 3'd3, 1, 1, 0, 0, 4'b0001);
    zone = 4'b0100;
    step();
    chk_all("t5_instant", 3'd4, 1, 0, 1, 0, 4'b0101);
    zone = 4'b0000;

    // 6a: asynchronous reset mid-ALARM, checked before the next edge.
    step();
    chk_all("t6_alarm", 3'd4, 1, 0, 1, 0, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t6_async_rst", 3'd0, 0, 0, 0, 0, 4'b0000);
    step();
    rst_n = 1'b1;
    step();

    // 6b: arm+disarm together in DISARMED, with an open zone: no fault.
    zone = 4'b0010; arm = 1'b1; disarm = 1'b1;
    step();
    arm = 1'b0; disarm = 1'b0; zone = 4'b0000;
    chk_all("t6_arm_disarm", 3'd0, 0, 0, 0, 0, 4'b0000);
    step();
    chk_all("t6_idle", 3'd0, 0, 0, 0, 0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
